// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the PC redirect controller: datapath field widths,
// redirect select codes, controller states and the select priority helper.
package pc_redirect_ctrl_pkg;

    localparam int IMM_W  = 16;
    localparam int ADDR_W = 26;

    typedef enum logic [1:0] {
        NONE,
        BR,
        JMP,
        JR
    } redir_sel_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT_D,
        REDIR,
        HALT
    } pcctl_state_t;

    // jr wins over j/jal, which wins over a taken branch
    function automatic redir_sel_t pick_sel(input logic jr, input logic jmp, input logic br);
        if (jr)  return JR;
        if (jmp) return JMP;
        if (br)  return BR;
        return NONE;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// PC block interface: the controller drives the next-PC selects, the hold line
// and the redirect targets; the PC block returns the current PC and PC+4.
interface pc_redirect_ctrl_if;
    import pc_redirect_ctrl_pkg::*;

    logic              source1;
    logic              source2;
    logic              source3;
    logic              ramfull;
    logic [IMM_W-1:0]  immediate;
    logic [ADDR_W-1:0] j_addr;
    logic [31:0]       jregaddr;
    logic [31:0]       imemaddr;
    logic [31:0]       returnaddr;

    modport pc (
        input  source1, source2, source3, ramfull, immediate, j_addr, jregaddr,
        output imemaddr, returnaddr
    );

    modport ctrl (
        output source1, source2, source3, ramfull, immediate, j_addr, jregaddr,
        input  imemaddr, returnaddr
    );

endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter; counts cycles where inc is high and sticks at all-ones.
module pc_redirect_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, hold once every bit is set
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller. Every redirect decision is registered, so the
// register-file -> PC mux -> imem address path is cut at the cost of one
// bubble per taken redirect. The hold line stays combinational because a
// missed fetch must freeze the PC in the same cycle.
//
//   state  | meaning
//   RUN    | fetching; plain instructions retire in one cycle
//   WAIT_D | data memory access outstanding, fetch disabled
//   REDIR  | one cycle driving the latched select and target into the PC
//   HALT   | absorbing; PC held until reset
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    pc_redirect_ctrl_if.ctrl        pcif,
    input  logic                    ihit,
    input  logic [31:0]             instr,
    input  logic                    is_beq,
    input  logic                    is_bne,
    input  logic                    is_j,
    input  logic                    is_jal,
    input  logic                    is_jr,
    input  logic                    halt,
    input  logic                    zero,
    input  logic [31:0]             rs_data,
    input  logic                    dmem_req,
    input  logic                    dhit,
    output logic                    imemREN,
    output logic                    link_wen,
    output logic [31:0]             link_wdat,
    output logic                    halted,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    pcctl_state_t      state;
    redir_sel_t        sel;
    logic              br_taken;
    logic              rdir;
    logic              hold;
    logic              src1_q;
    logic              src2_q;
    logic              src3_q;
    logic [IMM_W-1:0]  imm_q;
    logic [ADDR_W-1:0] jaddr_q;
    logic [31:0]       jreg_q;
    logic              unused_bits;

    // opcode bits and the current PC are not needed to make redirect decisions
    assign unused_bits = ^{instr[31:ADDR_W], pcif.imemaddr};

    // redirect decode for the instruction offered this cycle
    always_comb begin
        br_taken = (is_beq & zero) | (is_bne & ~zero);
        rdir     = is_j | is_jal | is_jr | br_taken;
        sel      = pick_sel(is_jr, is_j | is_jal, br_taken);
    end

    // PC hold per state; reset forces a hold so no partial redirect leaks out
    always_comb begin
        hold = 1'b1;
        case (state)
            RUN:     hold = ~ihit | dmem_req | rdir | halt;
            WAIT_D:  hold = ~dhit;
            REDIR:   hold = 1'b0;
            HALT:    hold = 1'b1;
            default: hold = 1'b1;
        endcase
    end

    assign pcif.ramfull   = hold | ~nRST;
    assign imemREN        = (state == RUN);
    assign pcif.source1   = src1_q;
    assign pcif.source2   = src2_q;
    assign pcif.source3   = src3_q;
    assign pcif.immediate = imm_q;
    assign pcif.j_addr    = jaddr_q;
    assign pcif.jregaddr  = jreg_q;

    // controller FSM with registered selects, targets and link write
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            src1_q    <= 1'b0;
            src2_q    <= 1'b0;
            src3_q    <= 1'b0;
            imm_q     <= '0;
            jaddr_q   <= '0;
            jreg_q    <= '0;
            link_wen  <= 1'b0;
            link_wdat <= '0;
            halted    <= 1'b0;
        end else begin
            src1_q   <= 1'b0;
            src2_q   <= 1'b0;
            src3_q   <= 1'b0;
            link_wen <= 1'b0;
            case (state)
                RUN: begin
                    if (ihit) begin
                        if (halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (rdir) begin
                            state   <= REDIR;
                            src1_q  <= (sel == BR);
                            src2_q  <= (sel == JMP);
                            src3_q  <= (sel == JR);
                            imm_q   <= instr[IMM_W-1:0];
                            jaddr_q <= instr[ADDR_W-1:0];
                            jreg_q  <= rs_data;
                            if (is_jal && (sel == JMP)) begin
                                link_wen  <= 1'b1;
                                link_wdat <= pcif.returnaddr;
                            end
                        end else if (dmem_req) begin
                            state <= WAIT_D;
                        end
                    end
                end
                WAIT_D: begin
                    if (dhit) state <= RUN;
                end
                REDIR: begin
                    state <= RUN;
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    pc_redirect_ctrl_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (pcif.ramfull),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl. A small PC block model follows the
// select and hold lines; expected next-fetch PCs go into a scoreboard queue
// when each instruction is issued and are popped at the following fetch.
module tb_pc_redirect_ctrl;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit, is_beq, is_bne, is_j, is_jal, is_jr, halt, zero;
    logic        dmem_req, dhit;
    logic [31:0] instr, rs_data;
    logic        imemREN, link_wen, halted;
    logic [31:0] link_wdat;
    logic [15:0] stall_cnt;
    logic [31:0] pc;

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          exp_stall = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    pc_redirect_ctrl_if pif ();

    pc_redirect_ctrl #(
        .STALL_CNT_W (16)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .pcif      (pif),
        .ihit      (ihit),
        .instr     (instr),
        .is_beq    (is_beq),
        .is_bne    (is_bne),
        .is_j      (is_j),
        .is_jal    (is_jal),
        .is_jr     (is_jr),
        .halt      (halt),
        .zero      (zero),
        .rs_data   (rs_data),
        .dmem_req  (dmem_req),
        .dhit      (dhit),
        .imemREN   (imemREN),
        .link_wen  (link_wen),
        .link_wdat (link_wdat),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    assign pif.imemaddr   = pc;
    assign pif.returnaddr = pc + 32'd4;

    // PC block: holds on ramfull, otherwise loads the selected next PC
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) pc <= 32'd0;
        else if (!pif.ramfull) begin
            if (pif.source3)      pc <= pif.jregaddr;
            else if (pif.source2) pc <= {pc[31:28], pif.j_addr, 2'b00};
            else if (pif.source1) pc <= pc + 32'd4 + {{14{pif.immediate[15]}}, pif.immediate, 2'b00};
            else                  pc <= pc + 32'd4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ihit = 0; instr = 0; is_beq = 0; is_bne = 0; is_j = 0; is_jal = 0;
        is_jr = 0; halt = 0; zero = 0; rs_data = 0; dmem_req = 0; dhit = 0;
    endtask

    // entered at a falling edge with inputs set; checks the hold line, then
    // advances one clock and returns at the next falling edge
    task automatic cyc(input string tag, input logic exp_rf);
        #1;
        chk({tag, "_ramfull"}, {31'd0, pif.ramfull}, {31'd0, exp_rf});
        if (exp_rf) exp_stall++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic fetch_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed pc %h expected an entry", tag, pc);
        end else begin
            e = exp_q.pop_front();
            chk(tag, pc, e);
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] iw, input logic [31:0] next_pc,
                         input logic exp_rf);
        fetch_check({tag, "_pc"});
        ihit  = 1;
        instr = iw;
        exp_q.push_back(next_pc);
        cyc(tag, exp_rf);
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        ihit = 1;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ramfull", {31'd0, pif.ramfull}, 32'd1);
        chk("rst_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        chk("rst_link_wen", {31'd0, link_wen}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        exp_q.push_back(32'd0);

        // plain instructions, one per cycle
        issue("alu0", 32'h0022_1820, 32'h04, 0);
        chk("alu_imemren", {31'd0, imemREN}, 32'd1);
        issue("alu1", 32'h0022_1820, 32'h08, 0);
        chk("alu_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        issue("alu2", 32'h0022_1820, 32'h0C, 0);
        issue("alu3", 32'h0022_1820, 32'h10, 0);

        // taken beq at 0x10, imm 3 -> 0x20
        is_beq = 1; zero = 1;
        issue("beq_t", 32'h1022_0003, 32'h20, 1);
        idle_inputs();
        #1;
        chk("beq_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'b001);
        chk("beq_imm", {16'd0, pif.immediate}, 32'h3);
        chk("beq_link_wen", {31'd0, link_wen}, 32'd0);
        chk("redir_imemren", {31'd0, imemREN}, 32'd0);
        cyc("beq_redir", 0);

        // not-taken beq: no bubble
        is_beq = 1; zero = 0;
        issue("beq_nt", 32'h1022_0003, 32'h24, 0);
        idle_inputs();
        chk("beq_nt_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);

        // jr with j also flagged: only source3, target stable through REDIR
        is_jr = 1; is_j = 1; rs_data = 32'h0000_0400;
        issue("jr", 32'h0800_0123, 32'h400, 1);
        idle_inputs();
        rs_data = 32'h0000_FFFF;
        #1;
        chk("jr_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'b100);
        chk("jr_target", pif.jregaddr, 32'h400);
        cyc("jr_redir", 0);
        chk("jr_target_after", pif.jregaddr, 32'h400);
        idle_inputs();

        // j at 0x400 -> 0x40, no link
        is_j = 1;
        issue("j", 32'h0800_0010, 32'h40, 1);
        idle_inputs();
        chk("j_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'b010);
        chk("j_link_wen", {31'd0, link_wen}, 32'd0);
        chk("j_addr", {6'd0, pif.j_addr}, 32'h10);
        cyc("j_redir", 0);

        // jal at 0x40 -> 0x80, links 0x44
        is_jal = 1; rs_data = 32'h0000_1234;
        issue("jal", 32'h0C00_0020, 32'h80, 1);
        idle_inputs();
        chk("jal_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'b010);
        chk("jal_link_wen", {31'd0, link_wen}, 32'd1);
        chk("jal_link_wdat", link_wdat, 32'h44);
        cyc("jal_redir", 0);
        chk("jal_link_wen_off", {31'd0, link_wen}, 32'd0);

        // fetch miss, then lw with dhit on the third wait cycle
        cyc("nofetch", 1);
        dmem_req = 1;
        issue("lw", 32'h8C22_0000, 32'h84, 1);
        idle_inputs();
        chk("lw_imemren", {31'd0, imemREN}, 32'd0);
        cyc("lw_w1", 1);
        cyc("lw_w2", 1);
        dhit = 1; ihit = 1;
        cyc("lw_dhit", 0);
        idle_inputs();
        chk("lw_stall_cnt", {16'd0, stall_cnt}, exp_stall);

        // reset asserted while waiting on data memory
        dmem_req = 1;
        issue("lw2", 32'h8C22_0000, 32'h88, 1);
        idle_inputs();
        nRST = 0;
        #1;
        chk("arst_ramfull", {31'd0, pif.ramfull}, 32'd1);
        chk("arst_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        chk("arst_imm", {16'd0, pif.immediate}, 32'd0);
        chk("arst_jaddr", {6'd0, pif.j_addr}, 32'd0);
        chk("arst_jreg", pif.jregaddr, 32'd0);
        chk("arst_link_wdat", link_wdat, 32'd0);
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("arst_pc", pc, 32'd0);
        @(negedge CLK);
        nRST = 1;
        exp_q.delete();
        exp_q.push_back(32'd0);
        exp_stall = 0;

        // halt together with a taken beq
        is_beq = 1; zero = 1; halt = 1;
        issue("halt", 32'h1022_0003, 32'h0, 1);
        idle_inputs();
        ihit = 1; is_j = 1;
        #1;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_imemren", {31'd0, imemREN}, 32'd0);
        chk("halt_src", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        cyc("halt1", 1);
        chk("halt_src1", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        cyc("halt2", 1);
        chk("halt_src2", {29'd0, pif.source3, pif.source2, pif.source1}, 32'd0);
        chk("halt_halted2", {31'd0, halted}, 32'd1);
        fetch_check("halt_pc");
        chk("halt_stall_cnt", {16'd0, stall_cnt}, exp_stall);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
